div_16by8_seq: RTL

Sequential signed-by-unsigned integer divider: a signed 16-bit dividend divided by an unsigned 8-bit divisor gives a signed 16-bit quotient and a signed 9-bit remainder. It undoes the scaling done by the 8-bit unsigned×signed multiplier in the filter datapath, for example to normalise accumulated filter sums by a gain or tap count. It uses a restoring shift-subtract core, produces one quotient bit per cycle, and has valid/ready handshakes on both sides.

---
 rtl/div_16by8_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/div_16by8_seq.sv
// Sequential signed-by-unsigned divider: 16-bit signed / 8-bit unsigned,
// restoring shift-subtract, one quotient bit per cycle, valid/ready on both sides.
module div_16by8_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_dividend,
    input  logic [7:0]  i_divisor,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_quot,
    output logic [8:0]  o_rem,
    output logic        o_dbz
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_cnt;
    logic [15:0] r_mag;
    logic [8:0]  r_part;
    logic [7:0]  r_div;
    logic        r_sign;
    logic [15:0] r_quot;
    logic [8:0]  r_rem;
    logic        r_dbz;

    logic        w_accept;
    logic        w_last;
    logic        w_ge;
    logic [8:0]  w_shift;
    logic [8:0]  w_part_nx;
    logic [15:0] w_mag_nx;
    logic [15:0] w_mag_in;

    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_DONE);
    assign o_quot   = r_quot;
    assign o_rem    = r_rem;
    assign o_dbz    = r_dbz;

    assign w_accept = o_ready & i_valid;
    assign w_last   = (r_cnt == 4'd0);

    // r_mag holds the dividend magnitude and fills with quotient bits from the LSB
    assign w_shift   = {r_part[7:0], r_mag[15]};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    assign w_part_nx = w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
    assign w_mag_nx  = {r_mag[14:0], w_ge};
    assign w_mag_in  = i_dividend[15] ? (16'd0 - i_dividend) : i_dividend;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (i_divisor == 8'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= 4'd0;
            r_mag  <= 16'd0;
            r_part <= 9'd0;
            r_div  <= 8'd0;
            r_sign <= 1'b0;
            r_quot <= 16'd0;
            r_rem  <= 9'd0;
            r_dbz  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_div  <= i_divisor;
                        r_sign <= i_dividend[15];
                        r_mag  <= w_mag_in;
                        r_part <= 9'd0;
                        r_cnt  <= 4'd15;
                        if (i_divisor == 8'd0) begin
                            r_quot <= i_dividend[15] ? 16'h8000 : 16'h7FFF;
                            r_rem  <= 9'd0;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_mag  <= w_mag_nx;
                    r_part <= w_part_nx;
                    r_cnt  <= r_cnt - 4'd1;
                    if (w_last) begin
                        r_quot <= r_sign ? (16'd0 - w_mag_nx) : w_mag_nx;
                        r_rem  <= r_sign ? (9'd0 - w_part_nx) : w_part_nx;
                        r_dbz  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
